// File: rtl/carfield_chip_pkg.sv
// Shared Carfield chip constants: PLL JTAG IDCODE, TAP instruction encodings and TAP state enum.
// TAP states use the IEEE 1149.1 reference encoding so tap_state_o matches common debug tooling.
package carfield_chip_pkg;

  localparam logic [31:0] CarfieldPllJtagIdCode = 32'h1abc_0db3;

  localparam logic [3:0] IrIdcode = 4'h1;
  localparam logic [3:0] IrPllCfg = 4'h2;
  localparam logic [3:0] IrBypass = 4'hF;

  typedef enum logic [3:0] {
    TapExit2Dr         = 4'h0,
    TapExit1Dr         = 4'h1,
    TapShiftDr         = 4'h2,
    TapPauseDr         = 4'h3,
    TapSelectIrScan    = 4'h4,
    TapUpdateDr        = 4'h5,
    TapCaptureDr       = 4'h6,
    TapSelectDrScan    = 4'h7,
    TapExit2Ir         = 4'h8,
    TapExit1Ir         = 4'h9,
    TapShiftIr         = 4'hA,
    TapPauseIr         = 4'hB,
    TapRunTestIdle     = 4'hC,
    TapUpdateIr        = 4'hD,
    TapCaptureIr       = 4'hE,
    TapTestLogicReset  = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    DrBypass,
    DrIdcode,
    DrPllCfg
  } dr_sel_e;

endpackage

// File: rtl/carfield_jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller; advances one state per synchronized TCK rise event.
// Latency: state_o reflects the new state one clk_i cycle after the rise event; no backpressure.
module carfield_jtag_tap_fsm
  import carfield_chip_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tck_rise_i,
  input  logic       tms_i,
  output tap_state_e state_o
);

  tap_state_e state_q, state_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= TapTestLogicReset;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tck_rise_i) begin
      case (state_q)
        TapTestLogicReset: state_d = tms_i ? TapTestLogicReset : TapRunTestIdle;
        TapRunTestIdle:    state_d = tms_i ? TapSelectDrScan   : TapRunTestIdle;
        TapSelectDrScan:   state_d = tms_i ? TapSelectIrScan   : TapCaptureDr;
        TapCaptureDr:      state_d = tms_i ? TapExit1Dr        : TapShiftDr;
        TapShiftDr:        state_d = tms_i ? TapExit1Dr        : TapShiftDr;
        TapExit1Dr:        state_d = tms_i ? TapUpdateDr       : TapPauseDr;
        TapPauseDr:        state_d = tms_i ? TapExit2Dr        : TapPauseDr;
        TapExit2Dr:        state_d = tms_i ? TapUpdateDr       : TapShiftDr;
        TapUpdateDr:       state_d = tms_i ? TapSelectDrScan   : TapRunTestIdle;
        TapSelectIrScan:   state_d = tms_i ? TapTestLogicReset : TapCaptureIr;
        TapCaptureIr:      state_d = tms_i ? TapExit1Ir        : TapShiftIr;
        TapShiftIr:        state_d = tms_i ? TapExit1Ir        : TapShiftIr;
        TapExit1Ir:        state_d = tms_i ? TapUpdateIr       : TapPauseIr;
        TapPauseIr:        state_d = tms_i ? TapExit2Ir        : TapPauseIr;
        TapExit2Ir:        state_d = tms_i ? TapUpdateIr       : TapShiftIr;
        TapUpdateIr:       state_d = tms_i ? TapSelectDrScan   : TapRunTestIdle;
        default:           state_d = TapTestLogicReset;
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/carfield_pll_jtag_tap.sv
// JTAG TAP oversampled by clk_i exposing IDCODE, BYPASS and a PLL configuration register.
// Latency: pin edges act 3 clk_i cycles later; pll_cfg_valid_o pulses one cycle on Update-DR; no backpressure.
module carfield_pll_jtag_tap
  import carfield_chip_pkg::*;
#(
  parameter logic [31:0]          IdCode    = CarfieldPllJtagIdCode,
  parameter int unsigned          IrWidth   = 4,
  parameter int unsigned          CfgWidth  = 32,
  parameter logic [CfgWidth-1:0]  CfgRstVal = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tck_i,
  input  logic                tms_i,
  input  logic                tdi_i,
  output logic                tdo_o,
  output logic                tdo_oe_o,
  output logic [CfgWidth-1:0] pll_cfg_o,
  output logic                pll_cfg_valid_o,
  output logic [3:0]          tap_state_o
);

  logic [1:0] tck_sync_q, tms_sync_q, tdi_sync_q;
  logic       tck_dly_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tck_sync_q <= '0;
      tms_sync_q <= '0;
      tdi_sync_q <= '0;
      tck_dly_q  <= 1'b0;
    end else begin
      tck_sync_q <= {tck_sync_q[0], tck_i};
      tms_sync_q <= {tms_sync_q[0], tms_i};
      tdi_sync_q <= {tdi_sync_q[0], tdi_i};
      tck_dly_q  <= tck_sync_q[1];
    end
  end

  logic tck_rise, tck_fall, tms, tdi;
  assign tck_rise = tck_sync_q[1] & ~tck_dly_q;
  assign tck_fall = ~tck_sync_q[1] & tck_dly_q;
  assign tms      = tms_sync_q[1];
  assign tdi      = tdi_sync_q[1];

  tap_state_e state;

  carfield_jtag_tap_fsm u_fsm (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .tck_rise_i (tck_rise),
    .tms_i      (tms),
    .state_o    (state)
  );

  logic in_shift_ir, in_shift_dr, in_shift;
  assign in_shift_ir = (state == TapShiftIr);
  assign in_shift_dr = (state == TapShiftDr);
  assign in_shift    = in_shift_ir | in_shift_dr;

  logic [IrWidth-1:0]  ir_q, ir_d, ir_sr_q, ir_sr_d;
  logic [31:0]         id_sr_q, id_sr_d;
  logic [CfgWidth-1:0] cfg_sr_q, cfg_sr_d, pll_cfg_q, pll_cfg_d;
  logic                byp_q, byp_d, cfg_vld_q, cfg_vld_d, tdo_q, tdo_d;

  // Unlisted instruction codes fall through to BYPASS.
  dr_sel_e dr_sel;
  always_comb begin
    dr_sel = DrBypass;
    if (ir_q == IrWidth'(IrBypass))      dr_sel = DrBypass;
    else if (ir_q == IrWidth'(IrIdcode)) dr_sel = DrIdcode;
    else if (ir_q == IrWidth'(IrPllCfg)) dr_sel = DrPllCfg;
  end

  logic dr_lsb;
  always_comb begin
    case (dr_sel)
      DrIdcode: dr_lsb = id_sr_q[0];
      DrPllCfg: dr_lsb = cfg_sr_q[0];
      default:  dr_lsb = byp_q;
    endcase
  end

  always_comb begin
    ir_d      = ir_q;
    ir_sr_d   = ir_sr_q;
    id_sr_d   = id_sr_q;
    cfg_sr_d  = cfg_sr_q;
    byp_d     = byp_q;
    pll_cfg_d = pll_cfg_q;
    cfg_vld_d = 1'b0;
    tdo_d     = tdo_q;

    if (state == TapTestLogicReset) ir_d = IrWidth'(IrIdcode);

    if (tck_rise) begin
      case (state)
        TapCaptureIr: ir_sr_d = IrWidth'(1);
        TapShiftIr:   ir_sr_d = {tdi, ir_sr_q[IrWidth-1:1]};
        TapUpdateIr:  ir_d    = ir_sr_q;
        TapCaptureDr: begin
          case (dr_sel)
            DrIdcode: id_sr_d  = IdCode;
            DrPllCfg: cfg_sr_d = pll_cfg_q;
            default:  byp_d    = 1'b0;
          endcase
        end
        TapShiftDr: begin
          case (dr_sel)
            DrIdcode: id_sr_d  = {tdi, id_sr_q[31:1]};
            DrPllCfg: cfg_sr_d = {tdi, cfg_sr_q[CfgWidth-1:1]};
            default:  byp_d    = tdi;
          endcase
        end
        TapUpdateDr: begin
          if (dr_sel == DrPllCfg) begin
            pll_cfg_d = cfg_sr_q;
            cfg_vld_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // TDO changes on the falling edge so the probe samples a stable bit at the next rise.
    if (tck_fall) begin
      if (in_shift_ir)      tdo_d = ir_sr_q[0];
      else if (in_shift_dr) tdo_d = dr_lsb;
      else                  tdo_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ir_q      <= IrWidth'(IrIdcode);
      ir_sr_q   <= '0;
      id_sr_q   <= '0;
      cfg_sr_q  <= '0;
      byp_q     <= 1'b0;
      pll_cfg_q <= CfgRstVal;
      cfg_vld_q <= 1'b0;
      tdo_q     <= 1'b0;
    end else begin
      ir_q      <= ir_d;
      ir_sr_q   <= ir_sr_d;
      id_sr_q   <= id_sr_d;
      cfg_sr_q  <= cfg_sr_d;
      byp_q     <= byp_d;
      pll_cfg_q <= pll_cfg_d;
      cfg_vld_q <= cfg_vld_d;
      tdo_q     <= tdo_d;
    end
  end

  assign tdo_o           = in_shift & tdo_q;
  assign tdo_oe_o        = in_shift;
  assign pll_cfg_o       = pll_cfg_q;
  assign pll_cfg_valid_o = cfg_vld_q;
  assign tap_state_o     = state;

endmodule

// File: tb/tb_carfield_pll_jtag_tap.sv
// Drives the PLL JTAG TAP through directed scans and a random TMS/TDI walk,
// comparing every bit against a behavioural TAP model.
module tb_carfield_pll_jtag_tap;

  localparam logic [31:0] IDCODE  = 32'h1abc_0db3;
  localparam logic [31:0] CFG_RST = 32'h0;

  localparam int S_EX2DR = 0,  S_EX1DR = 1,  S_SHDR = 2,  S_PDR  = 3;
  localparam int S_SELIR = 4,  S_UPDR  = 5,  S_CAPDR = 6, S_SELDR = 7;
  localparam int S_EX2IR = 8,  S_EX1IR = 9,  S_SHIR = 10, S_PIR  = 11;
  localparam int S_RTI   = 12, S_UPIR  = 13, S_CAPIR = 14, S_TLR = 15;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        tck_i = 1'b0;
  logic        tms_i = 1'b0;
  logic        tdi_i = 1'b0;
  logic        tdo_o, tdo_oe_o, pll_cfg_valid_o;
  logic [31:0] pll_cfg_o;
  logic [3:0]  tap_state_o;

  carfield_pll_jtag_tap dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .tck_i           (tck_i),
    .tms_i           (tms_i),
    .tdi_i           (tdi_i),
    .tdo_o           (tdo_o),
    .tdo_oe_o        (tdo_oe_o),
    .pll_cfg_o       (pll_cfg_o),
    .pll_cfg_valid_o (pll_cfg_valid_o),
    .tap_state_o     (tap_state_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_cycles = 0;

  always @(negedge clk_i) if (pll_cfg_valid_o === 1'b1) pulse_cycles++;

  // Behavioural model state
  int          nxt0 [16];
  int          nxt1 [16];
  int          m_state;
  logic [3:0]  m_ir, m_ir_sr;
  logic [63:0] m_dr;
  int          m_dr_len;
  logic [31:0] m_pll;
  int          m_pulses;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_edge(input int s, input int n0, input int n1);
    nxt0[s] = n0;
    nxt1[s] = n1;
  endtask

  task automatic init_tables();
    set_edge(S_TLR,   S_RTI,   S_TLR);
    set_edge(S_RTI,   S_RTI,   S_SELDR);
    set_edge(S_SELDR, S_CAPDR, S_SELIR);
    set_edge(S_CAPDR, S_SHDR,  S_EX1DR);
    set_edge(S_SHDR,  S_SHDR,  S_EX1DR);
    set_edge(S_EX1DR, S_PDR,   S_UPDR);
    set_edge(S_PDR,   S_PDR,   S_EX2DR);
    set_edge(S_EX2DR, S_SHDR,  S_UPDR);
    set_edge(S_UPDR,  S_RTI,   S_SELDR);
    set_edge(S_SELIR, S_CAPIR, S_TLR);
    set_edge(S_CAPIR, S_SHIR,  S_EX1IR);
    set_edge(S_SHIR,  S_SHIR,  S_EX1IR);
    set_edge(S_EX1IR, S_PIR,   S_UPIR);
    set_edge(S_PIR,   S_PIR,   S_EX2IR);
    set_edge(S_EX2IR, S_SHIR,  S_UPIR);
    set_edge(S_UPIR,  S_RTI,   S_SELDR);
  endtask

  task automatic model_rise(input bit tms, input bit tdi);
    case (m_state)
      S_CAPIR: m_ir_sr = 4'd1;
      S_SHIR:  m_ir_sr = (m_ir_sr >> 1) | (4'(tdi) << 3);
      S_UPIR:  m_ir = m_ir_sr;
      S_CAPDR: begin
        if (m_ir == 4'h1)      begin m_dr = 64'(IDCODE); m_dr_len = 32; end
        else if (m_ir == 4'h2) begin m_dr = 64'(m_pll);  m_dr_len = 32; end
        else                   begin m_dr = 64'd0;       m_dr_len = 1;  end
      end
      S_SHDR:  m_dr = (m_dr >> 1) | (64'(tdi) << (m_dr_len - 1));
      S_UPDR:  if (m_ir == 4'h2) begin m_pll = m_dr[31:0]; m_pulses++; end
      default: ;
    endcase
    m_state = tms ? nxt1[m_state] : nxt0[m_state];
    if (m_state == S_TLR) m_ir = 4'h1;
  endtask

  // One full TCK period: low phase (TDO sampled), then rise and high phase with noisy TMS/TDI.
  task automatic jtag_bit(input bit tms, input bit tdi, output bit tdo);
    logic exp_tdo, exp_oe;
    @(negedge clk_i);
    tck_i = 1'b0;
    tms_i = tms;
    tdi_i = tdi;
    repeat ($urandom_range(4, 7)) @(negedge clk_i);
    exp_oe  = (m_state == S_SHIR) || (m_state == S_SHDR);
    exp_tdo = (m_state == S_SHIR) ? m_ir_sr[0] : (m_state == S_SHDR) ? m_dr[0] : 1'b0;
    check_val("tdo", 64'(tdo_o), 64'(exp_tdo));
    check_val("tdo_oe", 64'(tdo_oe_o), 64'(exp_oe));
    tdo = tdo_o;
    tck_i = 1'b1;
    model_rise(tms, tdi);
    repeat ($urandom_range(4, 7)) @(negedge clk_i);
    tms_i = 1'($urandom);
    tdi_i = 1'($urandom);
    check_val("state", 64'(tap_state_o), 64'(m_state));
    check_val("pll_cfg", 64'(pll_cfg_o), 64'(m_pll));
    check_val("valid_cycles", 64'(pulse_cycles), 64'(m_pulses));
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    tck_i = 1'b0;
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_i   = 1'b0;
    m_state = S_TLR;
    m_ir    = 4'h1;
    m_pll   = CFG_RST;
    @(negedge clk_i);
    check_val("rst_state", 64'(tap_state_o), 64'(S_TLR));
    check_val("rst_tdo", 64'(tdo_o), 64'd0);
    check_val("rst_tdo_oe", 64'(tdo_oe_o), 64'd0);
    check_val("rst_pll_cfg", 64'(pll_cfg_o), 64'(CFG_RST));
    check_val("rst_valid", 64'(pll_cfg_valid_o), 64'd0);
  endtask

  // From a Shift state: n bits, TMS high on the last one (lands in Exit1).
  task automatic shift_reg(input int n, input logic [63:0] din, output logic [63:0] dout);
    bit o;
    dout = '0;
    for (int i = 0; i < n; i++) begin
      jtag_bit(i == n - 1, din[i], o);
      dout[i] = o;
    end
  endtask

  task automatic load_ir(input logic [3:0] v);
    bit o;
    logic [63:0] d;
    jtag_bit(1, 0, o); jtag_bit(1, 0, o); jtag_bit(0, 0, o); jtag_bit(0, 0, o);
    shift_reg(4, 64'(v), d);
    jtag_bit(1, 0, o); jtag_bit(0, 0, o);
  endtask

  task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
    bit o;
    jtag_bit(1, 0, o); jtag_bit(0, 0, o); jtag_bit(0, 0, o);
    shift_reg(n, din, dout);
    jtag_bit(1, 0, o); jtag_bit(0, 0, o);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit          o;
    logic [63:0] d;
    int          p0;

    init_tables();
    m_state = S_TLR; m_ir = 4'h1; m_ir_sr = '0; m_dr = '0; m_dr_len = 1;
    m_pll = CFG_RST; m_pulses = 0;
    do_reset();

    // IDCODE read straight out of reset
    jtag_bit(0, 0, o);
    scan_dr(32, 64'd0, d);
    check_val("idcode_read", d[31:0], 64'(IDCODE));

    // PLL_CFG write then read back
    load_ir(4'h2);
    p0 = pulse_cycles;
    scan_dr(32, 64'hdead_beef, d);
    check_val("pll_write", 64'(pll_cfg_o), 64'hdead_beef);
    check_val("pll_pulse_once", 64'(pulse_cycles - p0), 64'd1);
    scan_dr(32, 64'hdead_beef, d);
    check_val("pll_readback", d[31:0], 64'hdead_beef);

    // Undefined instruction behaves as BYPASS: one-bit delay
    load_ir(4'h5);
    p0 = pulse_cycles;
    scan_dr(8, 64'hA5, d);
    check_val("bypass_out", d[7:0], 64'h4A);
    check_val("bypass_pll_keep", 64'(pll_cfg_o), 64'hdead_beef);
    check_val("bypass_no_pulse", 64'(pulse_cycles - p0), 64'd0);

    // Five TMS=1 from Shift-DR reaches Test-Logic-Reset and restores IDCODE
    jtag_bit(1, 0, o); jtag_bit(0, 0, o); jtag_bit(0, 0, o);
    for (int i = 0; i < 3; i++) jtag_bit(0, 1'($urandom), o);
    for (int i = 0; i < 5; i++) jtag_bit(1, 1'($urandom), o);
    check_val("tms5_tlr", 64'(tap_state_o), 64'(S_TLR));
    check_val("tms5_pll_keep", 64'(pll_cfg_o), 64'hdead_beef);
    jtag_bit(0, 0, o);
    scan_dr(32, 64'd0, d);
    check_val("tms5_ir_idcode", d[31:0], 64'(IDCODE));

    // Capture-IR pattern
    jtag_bit(1, 0, o); jtag_bit(1, 0, o); jtag_bit(0, 0, o); jtag_bit(0, 0, o);
    shift_reg(4, 64'd0, d);
    check_val("capture_ir", d[3:0], 64'h1);
    jtag_bit(1, 0, o); jtag_bit(0, 0, o);

    // Reset in the middle of a PLL_CFG shift
    load_ir(4'h2);
    jtag_bit(1, 0, o); jtag_bit(0, 0, o); jtag_bit(0, 0, o);
    for (int i = 0; i < 10; i++) jtag_bit(0, 1'($urandom), o);
    p0 = pulse_cycles;
    do_reset();
    check_val("midrst_pll", 64'(pll_cfg_o), 64'(CFG_RST));
    check_val("midrst_no_pulse", 64'(pulse_cycles - p0), 64'd0);

    // Random walk over the whole TAP graph
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else jtag_bit($urandom_range(0, 99) < 35, 1'($urandom), o);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
